ps2_mouse_pkt: RTL and testbench
================================

# ps2_mouse_pkt

PS/2 mouse packet assembler and buffer between the mouse-side `ps2_port` receiver and the SMC I2C register 0x21 ("read from mouse buffer"). It takes raw received bytes, frames them into 3-byte (or 4-byte IntelliMouse) movement packets and checks byte-0 sync. Only complete packets are committed into an internal byte buffer. The SMC drains the buffer one byte at a time, so the I2C host never observes a partial packet.

## Interface
- `BITDEPTH`, 4: buffer holds 2**BITDEPTH bytes; must be ≥ 3.
- `TIMEOUT_US`, 2000: inter-byte gap, in ck1us pulses, after which a partial packet is aborted; 1..4095.
- `clk6x`  in  1  system clock, 48 MHz.
- `resetn`  in  1  asynchronous, active-low reset.
- `ck1us`  in  1  1 µs strobe, 1T wide, from `pulser`.
- `rx_byte_i`  in  8  received byte from the PS/2 port.
- `rx_v_i`  in  1  `rx_byte_i` valid, 1T.
- `clear_i`  in  1  synchronous flush of buffer and assembler, 1T; SMC pulses it when it sends a mouse reset.
- `rd_data_o`  out  8  byte at the buffer head; valid while `empty_o`=0; 8'h00 when empty.
- `rd_deq_i`  in  1  consume the head byte, 1T; ignored when `empty_o`=1.
- `empty_o`  out  1  no committed byte available.
- `drop_cnt_o`  out  8  packets dropped for lack of space; saturates at 8'hFF.
- `sync_err_o`  out  1  1T pulse when a byte-0 candidate fails the sync check.

## Operation
- PKTLEN is 3, or 4 with the IntelliMouse option enabled.
- Pointers are BITDEPTH+1 bits and wrap naturally: `rd_ptr`, `commit_ptr`, `stage_ptr`.
  - `empty_o` = (`rd_ptr` == `commit_ptr`).
  - Free space = 2**BITDEPTH − (`stage_ptr` − `rd_ptr`), computed mod 2**(BITDEPTH+1).
- Assembler states: `S_B0`, `S_B1`, `S_B2`, plus `S_B3` with IntelliMouse only.
- In `S_B0`, on `rx_v_i`:
  - Bit 3 of the byte is 0: discard it, pulse `sync_err_o`, stay in `S_B0`.
  - Bit 3 is 1 and free space < PKTLEN: the packet is dropped. Go to `S_B1` with internal flag `drop`=1 (no writes this packet). At packet end, `drop_cnt_o` increments once, saturating.
  - Otherwise: write the byte at `stage_ptr`, increment `stage_ptr`, set `drop`=0, go to `S_B1`.
- In `S_B1`..`S_B(PKTLEN−1)`, on `rx_v_i`:
  - Write the byte unless `drop`=1, and advance one state.
  - On the last byte, `commit_ptr` takes the new `stage_ptr` (when `drop`=0) and the state returns to `S_B0`.
- Gap timeout:
  - A 12-bit counter clears on every `rx_v_i` and counts `ck1us` pulses while state ≠ `S_B0`.
  - When it reaches `TIMEOUT_US`, the packet aborts: `stage_ptr` rolls back to `commit_ptr` and the state returns to `S_B0`. The abort does not count as a drop.
- `rd_deq_i` with `empty_o`=0 increments `rd_ptr`.
- `clear_i`:
  - Sets all pointers equal (`rd_ptr` and `stage_ptr` take `commit_ptr`), state to `S_B0`, timeout counter to 0.
  - Leaves `drop_cnt_o` unchanged.
  - Has priority over a same-cycle `rx_v_i` and `rd_deq_i`; both are lost.
- Simultaneous commit and dequeue in the same cycle are both applied.
- Dequeue during an assembly in progress never exposes staged bytes.

## Timing
- Reset values: all pointers 0, state `S_B0`, `rd_data_o`=8'h00, `empty_o`=1, `drop_cnt_o`=0, `sync_err_o`=0, timeout counter 0.
- Reset asserted mid-packet discards everything.
- Last packet byte on `rx_v_i` at cycle N:
  - `empty_o` is 0 at N+1.
  - `rd_data_o` shows byte 0 of the packet at N+1; it is a combinational read of the head register.
- `rd_deq_i` at cycle N: the next byte is on `rd_data_o` at N+1. The SMC may dequeue on consecutive cycles.
- `sync_err_o` is registered: it asserts at N+1 for a bad byte at N.
- A timeout abort takes effect the cycle after the `ck1us` pulse that reaches `TIMEOUT_US`.
- Back-to-back `rx_v_i` on consecutive cycles must be accepted, even though the PS/2 rate makes this impossible in practice.

## Configuration
- `PS2_MOUSE_WHEEL_EN` defined: PKTLEN=4 and state `S_B3` exists. Byte 3 (Z/wheel) is buffered unchecked.
- `PS2_MOUSE_WHEEL_EN` not defined: PKTLEN=3 and `S_B3` is not built.
- The space check, commit and timeout logic all use PKTLEN.

## Test plan
- Bytes 08,05,FB → `empty_o` falls 1 cycle after FB; three dequeues read 08,05,FB; `empty_o`=1 afterwards.
- Bytes 00,08,01,02 → one `sync_err_o` pulse; the packet 08,01,02 is committed.
- Bytes 08,01, then TIMEOUT_US+1 ck1us with no byte, then 09,02,03 → only 09,02,03 is buffered; `drop_cnt_o`=0.
- BITDEPTH=3, five 3-byte packets with no reads → packets 1-2 buffered (6 bytes), packets 3-5 dropped, `drop_cnt_o`=3; reads return packets 1-2 intact.
- Wrap-around, BITDEPTH=3: 20 packets each read immediately → every byte matches in order; no drops.
- `clear_i` pulsed after bytes 08,01 with one committed packet pending → `empty_o`=1. Next bytes 0A,01,02 → `rd_data_o`=0A.

Source files
------------

// File: rtl/ps2_mouse_pkt.sv
// ---------------------------------------------------------------------------
// ps2_mouse_pkt
//
// Packet assembler and byte buffer that sits between the PS/2 mouse receiver
// and the SMC "read from mouse buffer" I2C register. Raw received bytes are
// framed into movement packets. Byte 0 must have bit 3 set to be accepted as
// the start of a packet. A packet becomes visible to the reader only after
// its last byte arrives, so the I2C host never sees a partial packet.
//
// Packet length is 3 bytes by default. Defining the macro PS2_MOUSE_WHEEL_EN
// selects the 4-byte IntelliMouse format: a fourth state S_B3 is built, and
// the Z/wheel byte is buffered without any check.
//
// Parameters
//   BITDEPTH    buffer holds 2**BITDEPTH bytes (must be >= 3)
//   TIMEOUT_US  inter-byte gap, in ck1us pulses, that aborts a partial
//               packet (1..4095)
//
// Ports
//   clk6x       in   system clock (48 MHz)
//   resetn      in   asynchronous active-low reset
//   ck1us       in   1 us strobe, one clock wide
//   rx_byte_i   in   received byte from the PS/2 port
//   rx_v_i      in   rx_byte_i valid, one clock wide
//   clear_i     in   synchronous flush of buffer and assembler
//   rd_data_o   out  byte at the buffer head, 8'h00 when empty
//   rd_deq_i    in   consume the head byte (ignored when empty)
//   empty_o     out  no committed byte available
//   drop_cnt_o  out  packets dropped for lack of space, saturating
//   sync_err_o  out  one-clock pulse when a byte-0 candidate fails sync
// ---------------------------------------------------------------------------
module ps2_mouse_pkt #(
  parameter int BITDEPTH   = 4,
  parameter int TIMEOUT_US = 2000
) (
  input  logic       clk6x,
  input  logic       resetn,
  input  logic       ck1us,
  input  logic [7:0] rx_byte_i,
  input  logic       rx_v_i,
  input  logic       clear_i,
  output logic [7:0] rd_data_o,
  input  logic       rd_deq_i,
  output logic       empty_o,
  output logic [7:0] drop_cnt_o,
  output logic       sync_err_o
);

  localparam int DEPTH = 1 << BITDEPTH;
  localparam int PW    = BITDEPTH + 1;

`ifdef PS2_MOUSE_WHEEL_EN
  localparam int PKTLEN = 4;
`else
  localparam int PKTLEN = 3;
`endif

  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [PW:0]   DEPTH_W   = (PW+1)'(DEPTH);
  localparam logic [PW:0]   PKTLEN_W  = (PW+1)'(PKTLEN);
  localparam logic [11:0]   TMO_LAST  = 12'(TIMEOUT_US - 1);

  typedef enum logic [1:0] {
    S_B0,
    S_B1,
    S_B2
`ifdef PS2_MOUSE_WHEEL_EN
    , S_B3
`endif
  } state_t;

`ifdef PS2_MOUSE_WHEEL_EN
  localparam state_t S_LAST = S_B3;
`else
  localparam state_t S_LAST = S_B2;
`endif

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t          r_state;
  state_t          w_state_nxt;

  logic [PW-1:0]   r_rd_ptr;      // next byte handed to the reader
  logic [PW-1:0]   r_commit_ptr;  // end of the last complete packet
  logic [PW-1:0]   r_stage_ptr;   // end of the packet being assembled
  logic            r_drop;        // current packet is being discarded
  logic [7:0]      r_drop_cnt;
  logic            r_sync_err;
  logic [11:0]     r_tmo_cnt;
  logic [7:0]      r_mem [DEPTH];

  // -------------------------------------------------------------------------
  // Derived conditions
  // -------------------------------------------------------------------------
  logic [PW-1:0]   w_used;
  logic [PW:0]     w_free;
  logic            w_space_ok;
  logic            w_empty;
  logic            w_last;
  logic            w_tmo_hit;

  // Occupancy counts staged bytes too, so a new packet is only started when
  // all of it is guaranteed to fit in front of unread data.
  assign w_used     = r_stage_ptr - r_rd_ptr;
  assign w_free     = DEPTH_W - {1'b0, w_used};
  assign w_space_ok = (w_free >= PKTLEN_W);
  assign w_empty    = (r_rd_ptr == r_commit_ptr);
  assign w_last     = (r_state == S_LAST);

  // Abort on the ck1us pulse that makes the gap reach TIMEOUT_US, so the
  // state is back in S_B0 on the following cycle. A byte arriving on the
  // same cycle restarts the gap instead.
  assign w_tmo_hit  = (r_state != S_B0) && ck1us && !rx_v_i &&
                      (r_tmo_cnt == TMO_LAST);

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk6x or negedge resetn) begin
    if (!resetn) r_state <= S_B0;
    else         r_state <= w_state_nxt;
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    if (clear_i) begin
      w_state_nxt = S_B0;
    end else if (rx_v_i) begin
      case (r_state)
        S_B0:    if (rx_byte_i[3]) w_state_nxt = S_B1;
        S_B1:    w_state_nxt = S_B2;
`ifdef PS2_MOUSE_WHEEL_EN
        S_B2:    w_state_nxt = S_B3;
        S_B3:    w_state_nxt = S_B0;
`else
        S_B2:    w_state_nxt = S_B0;
`endif
        default: w_state_nxt = S_B0;
      endcase
    end else if (w_tmo_hit) begin
      w_state_nxt = S_B0;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: output decode
  // -------------------------------------------------------------------------
  logic w_wr;          // store rx_byte_i at stage_ptr
  logic w_start_keep;  // accepted byte 0, packet will be stored
  logic w_start_drop;  // accepted byte 0, no room: discard whole packet
  logic w_commit;      // last byte of a stored packet
  logic w_drop_done;   // last byte of a discarded packet
  logic w_sync_bad;    // byte-0 candidate without the sync bit
  logic w_abort;       // gap timeout, roll the staged bytes back

  always_comb begin
    w_wr         = 1'b0;
    w_start_keep = 1'b0;
    w_start_drop = 1'b0;
    w_commit     = 1'b0;
    w_drop_done  = 1'b0;
    w_sync_bad   = 1'b0;
    w_abort      = 1'b0;
    if (!clear_i) begin
      if (rx_v_i) begin
        if (r_state == S_B0) begin
          if (!rx_byte_i[3]) begin
            w_sync_bad = 1'b1;
          end else if (w_space_ok) begin
            w_wr         = 1'b1;
            w_start_keep = 1'b1;
          end else begin
            w_start_drop = 1'b1;
          end
        end else begin
          w_wr = !r_drop;
          if (w_last) begin
            w_commit    = !r_drop;
            w_drop_done = r_drop;
          end
        end
      end else begin
        w_abort = w_tmo_hit;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Pointers
  // -------------------------------------------------------------------------
  // Commit and dequeue touch different pointers, so both apply when they
  // coincide. A flush collapses the reader and stager onto the commit point,
  // which drops every committed byte as well as the packet in progress.
  always_ff @(posedge clk6x or negedge resetn) begin
    if (!resetn) begin
      r_rd_ptr     <= '0;
      r_commit_ptr <= '0;
      r_stage_ptr  <= '0;
    end else if (clear_i) begin
      r_rd_ptr    <= r_commit_ptr;
      r_stage_ptr <= r_commit_ptr;
    end else begin
      if (rd_deq_i && !w_empty) r_rd_ptr <= r_rd_ptr + PTR_ONE;

      if (w_abort)   r_stage_ptr <= r_commit_ptr;
      else if (w_wr) r_stage_ptr <= r_stage_ptr + PTR_ONE;

      // The last byte is written this cycle, so the commit point lands one
      // past the current stage pointer.
      if (w_commit) r_commit_ptr <= r_stage_ptr + PTR_ONE;
    end
  end

  // -------------------------------------------------------------------------
  // Packet bookkeeping, status outputs and gap timer
  // -------------------------------------------------------------------------
  always_ff @(posedge clk6x or negedge resetn) begin
    if (!resetn) begin
      r_drop     <= 1'b0;
      r_drop_cnt <= 8'h00;
      r_sync_err <= 1'b0;
      r_tmo_cnt  <= 12'd0;
    end else begin
      if (w_start_drop)      r_drop <= 1'b1;
      else if (w_start_keep) r_drop <= 1'b0;

      if (w_drop_done && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;

      r_sync_err <= w_sync_bad;

      if (clear_i || rx_v_i || w_tmo_hit) r_tmo_cnt <= 12'd0;
      else if ((r_state != S_B0) && ck1us) r_tmo_cnt <= r_tmo_cnt + 12'd1;
    end
  end

  // -------------------------------------------------------------------------
  // Byte storage
  // -------------------------------------------------------------------------
  // NOTE: the storage array is deliberately not reset; the pointers alone
  // decide which entries are meaningful, and a reset-free array maps onto
  // plain RAM.
  always_ff @(posedge clk6x) begin
    if (w_wr) r_mem[r_stage_ptr[BITDEPTH-1:0]] <= rx_byte_i;
  end

  assign rd_data_o  = w_empty ? 8'h00 : r_mem[r_rd_ptr[BITDEPTH-1:0]];
  assign empty_o    = w_empty;
  assign drop_cnt_o = r_drop_cnt;
  assign sync_err_o = r_sync_err;

endmodule

// File: tb/tb_ps2_mouse_pkt.sv
// ---------------------------------------------------------------------------
// tb_ps2_mouse_pkt
//
// Scoreboard bench for ps2_mouse_pkt (BITDEPTH=3, TIMEOUT_US=8). Stimulus
// updates a byte-level reference model (committed-byte queue, partial packet,
// gap count, expected drops and sync errors). A monitor pops the queue on
// every dequeue the DUT accepts and compares rd_data_o. Directed scenarios
// are followed by a randomized phase. Honours PS2_MOUSE_WHEEL_EN.
// ---------------------------------------------------------------------------
module tb_ps2_mouse_pkt;

  localparam int BD  = 3;
  localparam int CAP = 1 << BD;
  localparam int TMO = 8;
`ifdef PS2_MOUSE_WHEEL_EN
  localparam int PKTLEN = 4;
`else
  localparam int PKTLEN = 3;
`endif

  logic       clk6x = 1'b0;
  logic       resetn;
  logic       ck1us;
  logic [7:0] rx_byte_i;
  logic       rx_v_i;
  logic       clear_i;
  logic [7:0] rd_data_o;
  logic       rd_deq_i;
  logic       empty_o;
  logic [7:0] drop_cnt_o;
  logic       sync_err_o;

  ps2_mouse_pkt #(.BITDEPTH(BD), .TIMEOUT_US(TMO)) dut (
    .clk6x      (clk6x),
    .resetn     (resetn),
    .ck1us      (ck1us),
    .rx_byte_i  (rx_byte_i),
    .rx_v_i     (rx_v_i),
    .clear_i    (clear_i),
    .rd_data_o  (rd_data_o),
    .rd_deq_i   (rd_deq_i),
    .empty_o    (empty_o),
    .drop_cnt_o (drop_cnt_o),
    .sync_err_o (sync_err_o)
  );

  always #10 clk6x = ~clk6x;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  logic [7:0] model_q[$];   // committed, unread bytes in order
  logic [7:0] part[$];      // bytes of the packet being received
  int  m_pos   = 0;         // bytes of the current packet seen so far
  bit  m_drop  = 0;         // current packet is discarded for lack of room
  int  m_gap   = 0;         // ck1us pulses since the last byte
  int  exp_drop = 0;
  int  exp_sync = 0;
  int  sync_seen = 0;
  bit  rd_en  = 0;
  bit  mon_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_rx(input logic [7:0] b);
    m_gap = 0;
    if (m_pos == 0) begin
      if (!b[3]) begin
        exp_sync++;
      end else begin
        m_drop = (CAP - model_q.size()) < PKTLEN;
        part.delete();
        if (!m_drop) part.push_back(b);
        m_pos = 1;
      end
    end else begin
      if (!m_drop) part.push_back(b);
      m_pos++;
      if (m_pos == PKTLEN) begin
        if (m_drop) begin
          if (exp_drop < 255) exp_drop++;
        end else begin
          foreach (part[i]) model_q.push_back(part[i]);
        end
        part.delete();
        m_pos = 0;
      end
    end
  endtask

  task automatic model_ck();
    if (m_pos != 0) begin
      m_gap++;
      if (m_gap == TMO) begin
        part.delete();
        m_pos = 0;
        m_gap = 0;
      end
    end
  endtask

  task automatic model_flush();
    model_q.delete();
    part.delete();
    m_pos = 0;
    m_gap = 0;
  endtask

  // ---------------- drivers (called at posedge + 1) ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk6x); #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte_i = b;
    rx_v_i    = 1'b1;
    model_rx(b);
    @(posedge clk6x); #1;
    rx_v_i    = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
`ifdef PS2_MOUSE_WHEEL_EN
    send_byte(8'h7F);
`endif
  endtask

  task automatic pulse_ck();
    ck1us = 1'b1;
    model_ck();
    @(posedge clk6x); #1;
    ck1us = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_i = 1'b1;
    model_flush();
    @(posedge clk6x); #1;
    clear_i = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    rd_en = 1;
    while ((model_q.size() != 0 || !empty_o) && n < 400) begin
      @(posedge clk6x); #1;
      n++;
    end
    check("drain_in_time", 32'(n < 400), 32'd1);
    check("empty_after_drain", 32'(empty_o), 32'd1);
  endtask

  // ---------------- reader ----------------
  initial begin
    rd_deq_i = 1'b0;
    forever begin
      @(posedge clk6x); #1;
      rd_deq_i = rd_en && !empty_o && ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk6x) begin
    if (mon_en && resetn) begin
      if (sync_err_o) sync_seen++;
      if (rd_deq_i && !empty_o && !clear_i) begin
        if (model_q.size() == 0) begin
          check("unexpected_byte", 32'(rd_data_o), 32'hFFFF_FFFF);
        end else begin
          check("rd_data", 32'(rd_data_o), 32'(model_q.pop_front()));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    resetn    = 1'b0;
    ck1us     = 1'b0;
    rx_byte_i = 8'h00;
    rx_v_i    = 1'b0;
    clear_i   = 1'b0;
    #35;
    check("reset_empty", 32'(empty_o), 32'd1);
    check("reset_rd_data", 32'(rd_data_o), 32'h00);
    check("reset_drop_cnt", 32'(drop_cnt_o), 32'h00);
    check("reset_sync_err", 32'(sync_err_o), 32'd0);
    resetn = 1'b1;
    @(posedge clk6x); #1;
    mon_en = 1;

    // Basic packet: empty falls right after the last byte, head shows byte 0.
    rd_en = 0;
    send_pkt(8'h08, 8'h05, 8'hFB);
    check("pkt_empty_fall", 32'(empty_o), 32'd0);
    check("pkt_head", 32'(rd_data_o), 32'h08);
    wait_drain();

    // Bad sync byte followed by a good packet.
    rd_en = 0;
    send_byte(8'h00);
    check("sync_err_pulse", 32'(sync_err_o), 32'd1);
    send_pkt(8'h08, 8'h01, 8'h02);
    check("sync_err_cleared", 32'(sync_err_o), 32'd0);
    check("after_sync_head", 32'(rd_data_o), 32'h08);
    wait_drain();
    check("sync_count", 32'(sync_seen), 32'(exp_sync));

    // Gap timeout aborts a partial packet without counting a drop.
    rd_en = 0;
    send_byte(8'h08);
    send_byte(8'h01);
    for (int i = 0; i < TMO + 1; i++) begin
      pulse_ck();
      idle(1);
    end
    check("timeout_still_empty", 32'(empty_o), 32'd1);
    send_pkt(8'h09, 8'h02, 8'h03);
    check("timeout_head", 32'(rd_data_o), 32'h09);
    wait_drain();
    check("timeout_no_drop", 32'(drop_cnt_o), 32'd0);

    // Overflow: five packets with no reads, only two fit.
    rd_en = 0;
    for (int p = 0; p < 5; p++) send_pkt(8'h08 + 8'(p), 8'h10 + 8'(p), 8'h20 + 8'(p));
    check("overflow_drops", 32'(drop_cnt_o), 32'd3);
    check("overflow_model_drops", 32'(drop_cnt_o), 32'(exp_drop));
    check("overflow_head", 32'(rd_data_o), 32'h08);
    wait_drain();

    // Wrap-around: many packets, each drained before the next.
    for (int p = 0; p < 20; p++) begin
      send_pkt(8'h08 | 8'($urandom_range(0, 255)), 8'($urandom), 8'($urandom));
      wait_drain();
    end
    check("wrap_no_new_drops", 32'(drop_cnt_o), 32'd3);

    // Flush with a committed packet pending and a partial one in progress.
    rd_en = 0;
    send_pkt(8'h08, 8'hAA, 8'hBB);
    send_byte(8'h08);
    send_byte(8'h01);
    pulse_clear();
    check("clear_empty", 32'(empty_o), 32'd1);
    check("clear_keeps_drops", 32'(drop_cnt_o), 32'd3);
    send_pkt(8'h0A, 8'h01, 8'h02);
    check("clear_next_head", 32'(rd_data_o), 32'h0A);
    wait_drain();

    // Reset in the middle of a packet discards it and clears the drop count.
    rd_en = 0;
    send_byte(8'h08);
    send_byte(8'h01);
    resetn = 1'b0;
    model_flush();
    exp_drop = 0;
    #3;
    check("midreset_empty", 32'(empty_o), 32'd1);
    check("midreset_drop_cnt", 32'(drop_cnt_o), 32'd0);
    resetn = 1'b1;
    idle(1);
    send_pkt(8'h0C, 8'h44, 8'h55);
    check("midreset_head", 32'(rd_data_o), 32'h0C);
    wait_drain();

    // Randomized traffic: bytes, strobes, idle, occasional flush, bursty reads.
    for (int c = 0; c < 4000; c++) begin
      int r;
      if (c % 64 == 0) rd_en = ($urandom_range(0, 2) != 0);
      r = int'($urandom_range(0, 9));
      if ($urandom_range(0, 299) == 0) begin
        pulse_clear();
      end else if (r < 4) begin
        send_byte(8'($urandom));
      end else if (r < 6) begin
        pulse_ck();
      end else begin
        idle(1);
      end
    end
    wait_drain();
    check("random_drop_cnt", 32'(drop_cnt_o), 32'(exp_drop));
    check("random_sync_count", 32'(sync_seen), 32'(exp_sync));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
